// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the receive and transmit sides.
//   uart_state_e : receiver FSM states
//   OVERSAMPLE   : sub-bit ticks per bit period
//   MID_TICK     : tick index (from the start-bit edge) that lands mid-bit
//   baud_div()   : clock cycles per oversample tick (integer division)
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_buf.sv
// Receive byte FIFO, first-word-fall-through.
//   clk, reset  : core clock, asynchronous active-high reset
//   push        : write push_data this cycle (may be refused when full)
//   push_data   : byte to store
//   rd_en       : pop the head byte; ignored while empty
//   rd_data     : head byte, 0 when empty
//   empty, full : occupancy flags
//   count       : current occupancy, 0..DEPTH
//   drop        : push was refused because the FIFO is full and not popping
// DEPTH must be a power of two so the pointers wrap for free.
module uart_rx_buf #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [7:0]      mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCount);
    assign count = count_q;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = rd_en && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;

    assign rd_data = empty ? 8'h00 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: rd_data is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 2-FF synchronizer, 16x oversample tick generator,
// start/data/stop FSM (LSB first) and a byte FIFO (uart_rx_buf).
//   clk, reset : core clock, asynchronous active-high reset
//   uart_rxd   : asynchronous serial input, idles high
//   rd_en      : pop head byte
//   clr_err    : one-cycle pulse clearing the sticky error flags
//   rd_data    : head byte (FWFT), 0 when empty
//   empty, full, count : FIFO status
//   frame_err  : sticky, stop bit sampled low
//   overrun    : sticky, byte dropped on a full FIFO
//   parity_err : sticky, even-parity mismatch (only with UART_RX_PARITY_EN)
//   INT_RX     : level interrupt, ~empty
// Build option: define UART_RX_PARITY_EN for an even-parity bit (11-bit frame).
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     uart_rxd,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     overrun,
`ifdef UART_RX_PARITY_EN
    output logic                     parity_err,
`endif
    output logic                     INT_RX
);

    localparam int unsigned DIV  = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DivW-1:0] DivLast  = DivW'(DIV - 1);
    localparam logic [3:0]      MidTick  = 4'(MID_TICK);
    localparam logic [3:0]      LastTick = 4'(OVERSAMPLE - 1);
    // Ticks after a low stop-bit sample before a still-low line may start a new
    // frame: past the end of the stop bit, so a sender releasing the line at the
    // stop-bit boundary never retriggers, while a held-low line re-frames
    // roughly every 10 bit-times.
    localparam logic [3:0]      RearmTick = 4'd11;

    // Synchronizer
    logic [1:0] sync_q;
    logic       rxd_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rxd};
        end
    end

    assign rxd_s = sync_q[1];

    // Free-running oversample tick
    logic [DivW-1:0] div_cnt_q;
    logic            tick;

    assign tick = (div_cnt_q == DivLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else if (tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DivW'(1);
        end
    end

    // Receive FSM
    uart_state_e state_q, state_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        armed_q, armed_d;
    logic        bit_end;
    logic        push;
    logic        frame_set;
    logic        drop;
    logic        frame_err_q;
    logic        overrun_q;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_q, par_bad_d;
    logic        par_set;
    logic        parity_err_q;
`endif

    assign bit_end = tick && (tick_cnt_q == LastTick);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        armed_d    = armed_q;
        push       = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        par_set    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (rxd_s || (tick && tick_cnt_q == RearmTick)) begin
                    armed_d = 1'b1;
                end
                // On a line that idles high, armed && low is the falling edge.
                if (armed_q && !rxd_s) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                end
            end
            StStart: begin
                if (tick && tick_cnt_q == MidTick) begin
                    if (rxd_s) begin
                        state_d = StIdle;
                    end else begin
                        // From here each 16-tick wrap of tick_cnt lands mid-bit.
                        state_d    = StData;
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                    end
                end
            end
            StData: begin
                if (bit_end) begin
                    shreg_d   = {rxd_s, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    par_bad_d = ^{shreg_q, rxd_s};
                    par_set   = ^{shreg_q, rxd_s};
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    armed_d = rxd_s;
                    if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad_q;
`else
                        push = 1'b1;
`endif
                    end else begin
                        frame_set = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            armed_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            armed_q    <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    // Sticky flags: a set in the same cycle as clr_err wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= frame_set || (frame_err_q && !clr_err);
            overrun_q    <= drop || (overrun_q && !clr_err);
`ifdef UART_RX_PARITY_EN
            parity_err_q <= par_set || (parity_err_q && !clr_err);
`endif
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif
    assign INT_RX    = !empty;

    uart_rx_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg_q),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .drop      (drop)
    );

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend at 64 clocks per bit (DIV = 4), DEPTH = 8.
// Reference model: a byte queue plus two sticky flags, updated per frame.
module tb_uart_rx_frontend;

    localparam int unsigned BAUD     = 9600;
    localparam int unsigned CLK_FREQ = 64 * BAUD;
    localparam int unsigned DEPTH    = 8;
    localparam int          BIT_CYC  = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rxd;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       frame_err;
    logic       overrun;
    logic       INT_RX;

    uart_rx_frontend #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rxd  (uart_rxd),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .INT_RX    (INT_RX)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] q[$];
    logic       fe;
    logic       ov;
    int         push_lat;
    int         dummy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] head;
        head = (q.size() > 0) ? q[0] : 8'h00;
        check({tag, ".count"}, 32'(count), 32'(q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, ".int_rx"}, 32'(INT_RX), 32'(q.size() != 0));
        check({tag, ".rd_data"}, 32'(rd_data), 32'(head));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(fe));
        check({tag, ".overrun"}, 32'(overrun), 32'(ov));
    endtask

    // Model: one complete frame arrives.
    task automatic model_frame(input logic [7:0] d, input logic stop_b);
        if (!stop_b) fe = 1'b1;
        else if (q.size() < DEPTH) q.push_back(d);
        else ov = 1'b1;
    endtask

    // Drive one 10-bit frame. pop_at / clr_at: frame cycle at which rd_en /
    // clr_err is applied (-1 for none). push_at: first frame cycle whose edge
    // changed count (-1 if none). Frames start on a fixed phase of cyc so the
    // push cycle repeats from frame to frame.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int pop_at,
                              input int clr_at, output int push_at);
        logic [9:0] fr;
        logic [3:0] c0;
        fr      = {stop_b, d, 1'b0};
        push_at = -1;
        while (cyc % 4 != 0) @(negedge clk);
        c0 = count;
        for (int c = 0; c < 10 * BIT_CYC; c++) begin
            uart_rxd = fr[c / BIT_CYC];
            rd_en    = (c == pop_at);
            clr_err  = (c == clr_at);
            @(negedge clk);
            if (push_at < 0 && count != c0) push_at = c;
        end
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        uart_rxd = 1'b1;
    endtask

    task automatic rx(input logic [7:0] d, input logic stop_b);
        send_frame(d, stop_b, -1, -1, dummy);
        model_frame(d, stop_b);
        repeat (16) @(negedge clk);
    endtask

    task automatic pop_one(input string tag);
        if (q.size() > 0) check({tag, ".head"}, 32'(rd_data), 32'(q[0]));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check({tag, ".count_after"}, 32'(count), 32'(q.size()));
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        fe = 1'b0;
        ov = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [9:0] fr;
        logic       sb;
        reset    = 1'b1;
        uart_rxd = 1'b1;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        fe       = 1'b0;
        ov       = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset_held");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_all("reset_done");

        // Single byte, latency calibration
        send_frame(8'hA5, 1'b1, -1, -1, push_lat);
        model_frame(8'hA5, 1'b1);
        check("latency_in_range", 32'(push_lat >= 600 && push_lat <= 620), 32'd1);
        repeat (16) @(negedge clk);
        check_all("rx_a5");
        pop_one("pop_a5");
        check_all("after_pop_a5");

        // Short low glitch on an idle line
        uart_rxd = 1'b0;
        repeat (10) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (200) @(negedge clk);
        check_all("glitch");

        // Framing error, then clear
        rx(8'h3C, 1'b0);
        check_all("frame_err");
        clear_errs();
        check_all("frame_err_cleared");

        // Overrun: nine bytes, no pops
        for (int i = 1; i <= 9; i++) rx(8'(i), 1'b1);
        check_all("overrun");
        for (int i = 0; i < 8; i++) pop_one("drain_ovr");
        check_all("drained_ovr");

        // Full FIFO with a pop in the same cycle as the ninth push
        clear_errs();
        for (int i = 1; i <= 8; i++) rx(8'(i), 1'b1);
        check_all("refill");
        send_frame(8'h09, 1'b1, push_lat, -1, dummy);
        void'(q.pop_front());
        q.push_back(8'h09);
        repeat (16) @(negedge clk);
        check_all("push_pop_full");
        for (int i = 0; i < 8; i++) pop_one("drain_pp");
        check_all("drained_pp");

        // clr_err on the very cycle a framing error is flagged: the set wins
        send_frame(8'h77, 1'b0, -1, push_lat, dummy);
        model_frame(8'h77, 1'b0);
        repeat (16) @(negedge clk);
        check_all("set_beats_clear");
        clear_errs();

        // Randomized traffic
        for (int k = 0; k < 16; k++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            rx(d, sb);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            check_all("rand_rx");
            for (int p = $urandom_range(0, 3); p > 0; p--) pop_one("rand_pop");
            if ($urandom_range(0, 4) == 0) clear_errs();
        end
        while (q.size() > 0) pop_one("rand_drain");
        clear_errs();
        check_all("rand_end");

        // Reset during data bit 4
        rx(8'h12, 1'b1);
        fr = {1'b1, 8'hC3, 1'b0};
        while (cyc % 4 != 0) @(negedge clk);
        for (int c = 0; c < 5 * BIT_CYC + 20; c++) begin
            uart_rxd = fr[c / BIT_CYC];
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        q.delete();
        fe = 1'b0;
        ov = 1'b0;
        check_all("reset_mid");
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_all("after_reset");
        rx(8'h55, 1'b1);
        check_all("rx_55");
        pop_one("pop_55");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
